// File: rtl/video_stream_out_if.sv
// Pixel-stream bundle: FIFO read side plus registered video timing/pixel outputs.
// master = the stream generator, slave = the FIFO/display side.
interface video_stream_out_if;
    logic        fifo_empty;
    logic [23:0] fifo_data;
    logic        fifo_rd_en;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [23:0] rgb;
    logic        frame_start;

    modport master (
        input  fifo_empty, fifo_data,
        output fifo_rd_en, hsync, vsync, de, rgb, frame_start
    );

    modport slave (
        output fifo_empty, fifo_data,
        input  fifo_rd_en, hsync, vsync, de, rgb, frame_start
    );
endinterface

// File: rtl/video_stream_out.sv
// Raster timing generator that streams FIFO pixels to a registered RGB888 output.
// Defining VSO_TEST_PATTERN_EN adds an 8-bar colour pattern selected by test_mode.
module video_stream_out #(
    parameter int          H_ACTIVE        = 640,
    parameter int          H_FP            = 16,
    parameter int          H_SYNC          = 96,
    parameter int          H_BP            = 48,
    parameter int          V_ACTIVE        = 480,
    parameter int          V_FP            = 10,
    parameter int          V_SYNC          = 2,
    parameter int          V_BP            = 33,
    parameter int          SYNC_POL        = 0,
    parameter int          IN_FMT          = 0,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF0000
) (
    input  logic               clock25,
    input  logic               resetn,
    input  logic               enable,
    input  logic               test_mode,
    video_stream_out_if.master vid,
    output logic [15:0]        underflow_cnt
);
    // state  | meaning
    // IDLE   | stream disabled, pixels black, no FIFO reads
    // ARM    | enabled, waiting for the last pixel of the current frame
    // STREAM | reading the FIFO and emitting pixels

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
    localparam logic          SYNC_ACT = (SYNC_POL != 0);

    typedef enum logic [1:0] {IDLE, ARM, STREAM} state_t;

    state_t        state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last, v_last;
    logic          px_active, hs_on, vs_on;
    logic          streaming, tp_on, rd_en, underflow;

    logic s1_active, s1_hs, s1_vs, s1_rd, s1_uf, s1_first;

    function automatic logic [23:0] to_rgb888(input logic [23:0] d);
        if (IN_FMT == 0)
            return {d[15:11], 3'b000, d[10:5], 2'b00, d[4:0], 3'b000};
        else
            return d;
    endfunction

`ifdef VSO_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    logic [2:0] s1_bar;
    logic       s1_tp;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    assign tp_on   = test_mode;
    assign bar_idx = 3'({h_cnt, 3'b000} / (HW + 3)'(H_ACTIVE));
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign tp_on            = 1'b0;
`endif

    assign h_last    = (h_cnt == H_LAST_C);
    assign v_last    = (v_cnt == V_LAST_C);
    assign px_active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hs_on     = (h_cnt >= H_SS_C) && (h_cnt < H_SE_C);
    assign vs_on     = (v_cnt >= V_SS_C) && (v_cnt < V_SE_C);

    // Gating with enable as well as state lets a dropped enable stop reads this clock.
    assign streaming      = (state == STREAM) && enable;
    assign rd_en          = streaming && px_active && !vid.fifo_empty && !tp_on;
    assign underflow      = streaming && px_active &&  vid.fifo_empty && !tp_on;
    assign vid.fifo_rd_en = rd_en;

    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else if (!enable) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= ARM;
                ARM:     if (h_last && v_last) state <= STREAM;
                STREAM:  state <= STREAM;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn)
            underflow_cnt <= '0;
        else if (underflow && (underflow_cnt != 16'hFFFF))
            underflow_cnt <= underflow_cnt + 16'd1;
    end

    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn) begin
            s1_active <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_rd     <= 1'b0;
            s1_uf     <= 1'b0;
            s1_first  <= 1'b0;
        end else begin
            s1_active <= px_active;
            s1_hs     <= hs_on;
            s1_vs     <= vs_on;
            s1_rd     <= rd_en;
            s1_uf     <= underflow;
            s1_first  <= streaming && (h_cnt == '0) && (v_cnt == '0);
        end
    end

`ifdef VSO_TEST_PATTERN_EN
    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn) begin
            s1_tp  <= 1'b0;
            s1_bar <= '0;
        end else begin
            s1_tp  <= tp_on;
            s1_bar <= bar_idx;
        end
    end
`endif

    // fifo_data is valid here, one clock after the read strobe.
    always_ff @(posedge clock25 or negedge resetn) begin
        if (!resetn) begin
            vid.hsync       <= ~SYNC_ACT;
            vid.vsync       <= ~SYNC_ACT;
            vid.de          <= 1'b0;
            vid.rgb         <= '0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.hsync       <= s1_hs ? SYNC_ACT : ~SYNC_ACT;
            vid.vsync       <= s1_vs ? SYNC_ACT : ~SYNC_ACT;
            vid.de          <= s1_active;
            vid.frame_start <= s1_first;
            if (s1_rd)
                vid.rgb <= to_rgb888(vid.fifo_data);
            else if (s1_uf)
                vid.rgb <= UNDERFLOW_COLOR;
`ifdef VSO_TEST_PATTERN_EN
            else if (s1_tp && s1_active)
                vid.rgb <= bar_color(s1_bar);
`endif
            else
                vid.rgb <= '0;
        end
    end
endmodule

// File: tb/tb_video_stream_out.sv
// Bench for video_stream_out on a reduced raster, with a position/frame-arithmetic
// reference model fed by randomized FIFO data and empty flags.
module tb_video_stream_out;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FR = HT * VT;
`ifdef VSO_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    typedef struct {
        bit act, hs, vs, rd, uf, tp, fs;
        int h;
    } stage_t;

    logic        clock25 = 1'b0;
    logic        resetn  = 1'b1;
    logic        enable, test_mode;
    logic [15:0] underflow_cnt;

    video_stream_out_if vif();

    video_stream_out #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(0), .IN_FMT(0), .UNDERFLOW_COLOR(24'hFF0000)
    ) dut (
        .clock25(clock25),
        .resetn(resetn),
        .enable(enable),
        .test_mode(test_mode),
        .vid(vif),
        .underflow_cnt(underflow_cnt)
    );

    always #20 clock25 = ~clock25;

    int          n_pass = 0, n_fail = 0, n_total = 0;
    int          kk = 0, en_start = 0, uf_model = 0, nreads = 0, base;
    bit          en_prev = 1'b0;
    stage_t      hist [4];
    logic [23:0] dat [4];
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, kk);
        end
    endtask

    function automatic logic [23:0] conv565(input logic [23:0] d);
        int r, g, b;
        r = int'(d >> 11) & 31;
        g = int'(d >> 5) & 63;
        b = int'(d) & 31;
        return 24'((r << 19) | (g << 10) | (b << 3));
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_hsync"}, vif.hsync, 1);
        chk({tag, "_vsync"}, vif.vsync, 1);
        chk({tag, "_de"}, vif.de, 0);
        chk({tag, "_rgb"}, vif.rgb, 0);
        chk({tag, "_frame_start"}, vif.frame_start, 0);
        chk({tag, "_rd_en"}, vif.fifo_rd_en, 0);
        chk({tag, "_ufcnt"}, underflow_cnt, 0);
    endtask

    // Leaves the bench just after the first post-reset clock edge is due: cycle 0 begins.
    task automatic do_reset(input logic en_during);
        resetn = 1'b0;
        enable = en_during;
        test_mode = 1'b0;
        vif.fifo_empty = 1'b0;
        #1;
        check_reset_values("rst_async");
        repeat (2) @(posedge clock25);
        #1;
        check_reset_values("rst_hold");
        resetn = 1'b1;
        kk = 0;
        en_prev = 1'b0;
        uf_model = 0;
    endtask

    // One pixel clock: drive inputs, check at the falling edge, advance past the rising edge.
    task automatic cyc(input logic en, input logic emp, input logic tm);
        stage_t      s, p;
        int          h, v, sstart;
        bit          strm;
        logic [23:0] d, exp_rgb;
        enable = en;
        vif.fifo_empty = emp;
        test_mode = tm;
        d = 24'($urandom);
        vif.fifo_data = d;
        dat[kk % 4] = d;
        if (en && !en_prev) en_start = kk;
        h = kk % HT;
        v = (kk / HT) % VT;
        sstart = ((en_start + 2 + FR - 1) / FR) * FR;
        strm = en && (kk >= sstart);
        s.act = (h < HA) && (v < VA);
        s.hs = (h >= HA + HFP) && (h < HA + HFP + HS);
        s.vs = (v >= VA + VFP) && (v < VA + VFP + VS);
        s.tp = TP && tm;
        s.rd = strm && s.act && !emp && !s.tp;
        s.uf = strm && s.act && emp && !s.tp;
        s.fs = strm && (h == 0) && (v == 0);
        s.h = h;
        @(negedge clock25);
        chk("rd_en", vif.fifo_rd_en, s.rd);
        if (kk >= 2) begin
            p = hist[(kk - 2) % 4];
            if (p.rd) exp_rgb = conv565(dat[(kk - 1) % 4]);
            else if (p.uf) exp_rgb = 24'hFF0000;
            else if (p.tp && p.act) exp_rgb = bars[p.h * 8 / HA];
            else exp_rgb = 24'h0;
        end else begin
            p = '{act: 0, hs: 0, vs: 0, rd: 0, uf: 0, tp: 0, fs: 0, h: 0};
            exp_rgb = 24'h0;
        end
        chk("hsync", vif.hsync, !p.hs);
        chk("vsync", vif.vsync, !p.vs);
        chk("de", vif.de, p.act);
        chk("rgb", vif.rgb, exp_rgb);
        chk("frame_start", vif.frame_start, p.fs);
        chk("underflow_cnt", underflow_cnt, uf_model);
        if (s.uf && uf_model < 65535) uf_model++;
        if (vif.fifo_rd_en === 1'b1) nreads++;
        hist[kk % 4] = s;
        @(posedge clock25);
        #1;
        kk++;
        en_prev = en;
    endtask

    initial begin
        enable = 1'b0;
        test_mode = 1'b0;
        vif.fifo_empty = 1'b0;
        vif.fifo_data = '0;
        #5;
        do_reset(1'b0);

        // Disabled: timing runs, no reads, black output.
        for (int i = 0; i < 60; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);

        // Enable mid-frame: streaming waits for the next frame boundary.
        while (kk < FR) cyc(1'b1, 1'b0, 1'b0);
        nreads = 0;
        for (int i = 0; i < FR; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("reads_per_frame", nreads, HA * VA);

        // Random FIFO starvation.
        for (int i = 0; i < FR; i++) cyc(1'b1, 1'($urandom_range(0, 5) == 0), 1'b0);

        // Five-pixel underflow burst mid-line.
        while (!((kk % HT == 4) && ((kk / HT) % VT == 2))) cyc(1'b1, 1'b0, 1'b0);
        base = uf_model;
        nreads = 0;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
        chk("uf_burst_cnt", underflow_cnt, base + 5);
        chk("uf_burst_no_reads", nreads, 0);

        // Enable dropped mid-line, then restored.
        while ((kk % HT) != 7) cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < FR + FR / 2; i++) cyc(1'b1, 1'($urandom_range(0, 7) == 0), 1'b0);

        // test_mode asserted for a full frame.
        for (int i = 0; i < FR; i++) cyc(1'b1, 1'($urandom_range(0, 3) == 0), 1'b1);

        // Asynchronous reset mid-line while streaming.
        while (!((kk % HT == 9) && ((kk / HT) % VT == 1))) cyc(1'b1, 1'b0, 1'b0);
        do_reset(1'b1);
        for (int i = 0; i < FR + 40; i++) cyc(1'b1, 1'($urandom_range(0, 7) == 0), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/video_stream_out.md
VIDEO_STREAM_OUT -- requirements
Module: video_stream_out

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16; H_SYNC, default 96; H_BP, default 48: horizontal porch and sync widths in clocks.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameter V_FP, default 10; V_SYNC, default 2; V_BP, default 33: vertical porch and sync widths in lines.
REQ-005 Parameter SYNC_POL, default 0: active sync level; 0 means active-low.
REQ-006 Parameter IN_FMT, default 0: input pixel format; 0 is RGB565 in fifo_data[15:0], 1 is RGB888 in fifo_data[23:0].
REQ-007 Parameter UNDERFLOW_COLOR, default 24'hFF0000: pixel emitted when FIFO data is missing.
REQ-008 clock25  in  1  pixel clock; all logic rises on it.
REQ-009 resetn  in  1  asynchronous, active-low reset.
REQ-010 enable  in  1  stream enable, synchronous level.
REQ-011 fifo_empty  in  1  source FIFO empty flag.
REQ-012 fifo_data  in  24  FIFO read data, valid one clock after fifo_rd_en.
REQ-013 fifo_rd_en  out  1  FIFO read strobe, combinational from registered state.
REQ-014 test_mode  in  1  selects colour bars (see REQ-033).
REQ-015 hsync, vsync, de  out  1 each  registered video timing.
REQ-016 rgb  out  24  registered RGB888 pixel.
REQ-017 frame_start  out  1  one-clock pulse aligned with output pixel (0,0).
REQ-018 underflow_cnt  out  16  saturating count of underflowed pixels.

Function
REQ-019 h_cnt SHALL run 0..H_TOTAL-1 and wrap, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; v_cnt SHALL increment when h_cnt wraps and SHALL run 0..V_TOTAL-1.
REQ-020 Counter pixel is active iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hsync is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync follows the same rule on v_cnt.
REQ-021 FSM states: IDLE, ARM, STREAM; reset state is IDLE.
REQ-022 IDLE->ARM when enable=1; ARM->STREAM at the counter position h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1; any state->IDLE in the same clock that enable=0 is sampled.
REQ-023 fifo_rd_en=1 iff state=STREAM, counter pixel active, and fifo_empty=0; it SHALL never assert when fifo_empty=1.
REQ-024 Output pipeline is 2 clocks: stage 1 captures active flag, sync levels, and rd_en; stage 2 registers hsync, vsync, de, and rgb, so all outputs stay mutually aligned.
REQ-025 rgb for an active pixel in STREAM whose read was issued: IN_FMT=0 gives {R5,3'b0,G6,2'b0,B5,3'b0}; IN_FMT=1 passes fifo_data[23:0] through.
REQ-026 Active pixel in STREAM with fifo_empty=1 at stage 0: rgb=UNDERFLOW_COLOR and underflow_cnt increments by 1, saturating at 16'hFFFF.
REQ-027 rgb=24'h000000 whenever the output de=0, and for all pixels in IDLE or ARM.
REQ-028 Sync and de generation SHALL continue in every state; enable affects only pixel data and FIFO reads.
REQ-029 frame_start SHALL pulse when the stage-2 pixel is (0,0) and state was STREAM at stage 0.
REQ-030 Dropping enable mid-line stops fifo_rd_en in the same clock; pixels already in the pipeline complete and then go black.

Reset
REQ-031 On resetn=0: h_cnt=0, v_cnt=0, state=IDLE, pipeline cleared, underflow_cnt=0.
REQ-032 Outputs during reset: hsync and vsync at the inactive level (~SYNC_POL), de=0, rgb=0, frame_start=0, fifo_rd_en=0.

Configuration
REQ-033 With macro VSO_TEST_PATTERN_EN defined and test_mode=1: fifo_rd_en is held 0 and rgb shows 8 equal vertical bars (white, yellow, cyan, green, magenta, red, blue, black) indexed by h_cnt*8/H_ACTIVE; underflow_cnt is not incremented.
REQ-034 Without VSO_TEST_PATTERN_EN: test_mode is ignored, and no pattern logic is synthesised.

Verification
REQ-035 Default parameters, enable=1, FIFO never empty with incrementing RGB565 data -> first read at frame boundary; 307200 reads per frame; rgb[23:19] equals data[15:11] with 2-clock alignment to de.
REQ-036 Timing check -> hsync low for 96 clocks every 800 clocks; vsync low for 2 lines every 525 lines; de high for 640 clocks per line on lines 0..479.
REQ-037 fifo_empty forced high for 5 active clocks mid-line -> 5 pixels of FF0000, underflow_cnt=5, and no rd_en during those clocks.
REQ-038 enable set mid-frame -> no reads and black output until v_cnt wraps, then frame_start pulse with the first pixel.
REQ-039 resetn pulsed low mid-line -> outputs take reset values asynchronously; after release, counters restart at (0,0) and state=IDLE.
REQ-040 VSO_TEST_PATTERN_EN defined, test_mode=1 -> rgb=FFFFFF at pixel 0, 000000 at pixel 639, bar edge at 80, fifo_rd_en=0 throughout.
